// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: JAL opcode, reset PC default,
// fetch FSM encodings, queue entry layout and the static next-PC predictor.
package inst_fetcher_pkg;

  localparam logic [6:0]  JALOP            = 7'b1101111;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pred_pc;
    logic [31:0] pc;
    logic [31:0] inst;
  } queue_entry_t;

  // JAL redirects statically; everything else falls through to pc+4.
  function automatic logic [31:0] predict_npc(input logic [31:0] pc,
                                              input logic [31:0] inst);
    logic [31:0] jimm;
    jimm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    if (inst[6:0] == JALOP) begin
      return pc + jimm;
    end
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular instruction queue of {pred_pc, pc, inst} entries with push/pop/clear.
// Head entry is read combinationally; clear dominates a same-cycle push or pop.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clear,
  input  logic                     push,
  input  queue_entry_t             push_data,
  input  logic                     pop,
  output queue_entry_t             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  queue_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[head];

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[tail] <= push_data;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch front end: owns the PC, issues one icache request at a time, predecodes
// JAL for a static redirect and queues fetched instructions for the decoder.
//
// Handshakes: the icache request is held stable while icache_req_valid=1 until a
// one-cycle icache_resp_valid; the decoder side transfers the head entry on any
// cycle where out_valid && out_ready, with out_* read straight from the queue head.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  output logic                   icache_req_valid,
  output logic [31:0]            icache_req_addr,
  input  logic                   icache_resp_valid,
  input  logic [31:0]            icache_resp_inst,
  output logic                   out_valid,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pred_pc,
  input  logic                   out_ready,
  input  logic                   flush_in,
  input  logic [31:0]            flush_pc,
  output fetch_state_e           dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  req_addr, req_addr_next;
  logic [31:0]  resp_npc;
  logic         push, pop;
  queue_entry_t push_data, head_data;
  logic         q_full, q_empty;

  inst_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear     (flush_in),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (dbg_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    push          = 1'b0;
    resp_npc      = predict_npc(pc, icache_resp_inst);
    push_data     = '{pred_pc: resp_npc, pc: pc, inst: icache_resp_inst};
    pop           = out_valid && out_ready;

    case (state)
      // Issuing only when a slot is free guarantees every response can be pushed.
      ST_IDLE: begin
        if (!q_full) begin
          state_next    = ST_REQ;
          req_addr_next = pc;
        end
      end
      ST_REQ: begin
        if (icache_resp_valid) begin
          state_next = ST_IDLE;
          push       = 1'b1;
          pc_next    = resp_npc;
        end
      end
      ST_DROP: begin
        if (icache_resp_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // A redirect wins over everything; an outstanding request must still drain.
    if (flush_in) begin
      push          = 1'b0;
      pc_next       = flush_pc;
      req_addr_next = req_addr;
      if (state != ST_IDLE && !icache_resp_valid) state_next = ST_DROP;
      else                                        state_next = ST_IDLE;
    end
  end

  assign icache_req_valid = (state != ST_IDLE);
  assign icache_req_addr  = req_addr;
  assign out_valid        = !q_empty;
  assign out_inst         = head_data.inst;
  assign out_pc           = head_data.pc;
  assign out_pred_pc      = head_data.pred_pc;
  assign dbg_state        = state;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: reset, streaming fetch, full-queue stall,
// push/pop at capacity, flush/drop corner cases and a JAL prediction table.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         icache_req_valid;
  logic [31:0]  icache_req_addr;
  logic         icache_resp_valid;
  logic [31:0]  icache_resp_inst;
  logic         out_valid;
  logic [31:0]  out_inst, out_pc, out_pred_pc;
  logic         out_ready = 1'b0;
  logic         flush_in = 1'b0;
  logic [31:0]  flush_pc = 32'h0;
  fetch_state_e dbg_state;
  logic [4:0]   dbg_count;

  int checks = 0;
  int failures = 0;

  inst_fetcher #(.DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_inst  (icache_resp_inst),
    .out_valid         (out_valid),
    .out_inst          (out_inst),
    .out_pc            (out_pc),
    .out_pred_pc       (out_pred_pc),
    .out_ready         (out_ready),
    .flush_in          (flush_in),
    .flush_pc          (flush_pc),
    .dbg_state         (dbg_state),
    .dbg_count         (dbg_count)
  );

  // clock / watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // icache model: auto mode answers after lat cycles from imem, else manual drive
  logic        auto_mode = 1'b1;
  int          lat = 0;
  int          wait_cnt = 0;
  logic        auto_resp = 1'b0;
  logic [31:0] auto_inst = 32'h0;
  logic        man_resp = 1'b0;
  logic [31:0] man_inst = 32'h0;
  logic [31:0] imem [logic [31:0]];

  assign icache_resp_valid = auto_mode ? auto_resp : man_resp;
  assign icache_resp_inst  = auto_mode ? auto_inst : man_inst;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h0000_0013;
  endfunction

  always @(negedge clk_in) begin
    if (icache_req_valid && !auto_resp) begin
      if (wait_cnt >= lat) begin
        auto_resp = 1'b1;
        auto_inst = mem_rd(icache_req_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      auto_resp = 1'b0;
      wait_cnt  = 0;
    end
  end

  // checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!icache_req_valid && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check(name, 32'(icache_req_valid), 32'd1);
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic do_flush(input logic [31:0] target);
    flush_in = 1'b1;
    flush_pc = target;
    @(negedge clk_in);
    flush_in = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exp_pred;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rises;
    logic prev;
    logic [31:0] rise_addr;

    vecs[0] = '{32'h0000_0020, 32'h0100_006F, 32'h0000_0030};  // jal x0,16
    vecs[1] = '{32'h0000_0000, 32'hFFDF_F06F, 32'hFFFF_FFFC};  // jal x0,-4
    vecs[2] = '{32'h0000_0100, 32'h0000_0013, 32'h0000_0104};  // addi nop
    vecs[3] = '{32'h0000_1000, 32'h0010_00EF, 32'h0000_1800};  // jal x1,0x800
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0000};  // pc+4 wraps
    vecs[5] = '{32'h0000_0040, 32'h0000_80E7, 32'h0000_0044};  // jalr not predicted
    vecs[6] = '{32'h7FFF_FFF0, 32'h0100_006F, 32'h8000_0000};  // jal across sign bit

    // reset
    repeat (3) @(negedge clk_in);
    check("rst_req_valid", 32'(icache_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(dbg_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_in = 1'b0;

    // streaming fetch, 1-cycle icache: request every other cycle
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_in);
      if (c % 2 == 1) begin
        check("stream_req_valid", 32'(icache_req_valid), 32'd1);
        check("stream_req_addr", icache_req_addr, 32'(4 * ((c - 1) / 2)));
      end else begin
        check("stream_req_gap", 32'(icache_req_valid), 32'd0);
      end
      if (c == 2) begin
        check("stream_out_valid", 32'(out_valid), 32'd1);
        check("stream_out_pc", out_pc, 32'h0);
        check("stream_out_pred", out_pred_pc, 32'h4);
        check("stream_out_inst", out_inst, 32'h13);
      end
    end

    // fill with out_ready=0: stops at 16, then one pop allows exactly one request
    for (int n = 0; n < 100 && dbg_count != 5'd16; n++) @(negedge clk_in);
    check("full_count", 32'(dbg_count), 32'd16);
    @(negedge clk_in);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_in);
      check("full_no_req", 32'(icache_req_valid), 32'd0);
    end
    check("full_head", out_pc, 32'h0);
    out_ready = 1'b1;
    @(negedge clk_in);
    out_ready = 1'b0;
    rises = 0;
    prev = icache_req_valid;
    rise_addr = 32'hDEAD_BEEF;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_in);
      if (icache_req_valid && !prev) begin
        rises++;
        rise_addr = icache_req_addr;
      end
      prev = icache_req_valid;
    end
    check("refill_one_req", 32'(rises), 32'd1);
    check("refill_addr", rise_addr, 32'h40);
    check("refill_count", 32'(dbg_count), 32'd16);
    check("refill_head", out_pc, 32'h4);

    // push and pop together at count 15
    auto_mode = 1'b0;
    out_ready = 1'b1;
    @(negedge clk_in);
    out_ready = 1'b0;
    wait_req("pp_req");
    check("pp_req_addr", icache_req_addr, 32'h44);
    check("pp_count_before", 32'(dbg_count), 32'd15);
    man_resp = 1'b1;
    man_inst = 32'h0000_0013;
    out_ready = 1'b1;
    @(negedge clk_in);
    man_resp = 1'b0;
    out_ready = 1'b0;
    check("pp_count_after", 32'(dbg_count), 32'd15);
    for (int k = 0; k < 15; k++) begin
      check("drain_pc", out_pc, 32'h0C + 32'(4 * k));
      check("drain_pred", out_pred_pc, 32'h10 + 32'(4 * k));
      out_ready = 1'b1;
      @(negedge clk_in);
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);

    // flush with a request outstanding; response arrives 3 cycles later
    wait_req("drop_req");
    check("drop_req_addr", icache_req_addr, 32'h48);
    do_flush(32'h100);
    check("drop_state", 32'(dbg_state), 32'(ST_DROP));
    check("drop_req_held", 32'(icache_req_valid), 32'd1);
    repeat (2) @(negedge clk_in);
    check("drop_state_hold", 32'(dbg_state), 32'(ST_DROP));
    man_resp = 1'b1;
    man_inst = 32'h0100_006F;
    @(negedge clk_in);
    man_resp = 1'b0;
    check("drop_not_pushed", 32'(out_valid), 32'd0);
    check("drop_idle", 32'(icache_req_valid), 32'd0);
    @(negedge clk_in);
    check("drop_new_req", 32'(icache_req_valid), 32'd1);
    check("drop_new_addr", icache_req_addr, 32'h100);

    // flush in the same cycle as resp and pop
    man_resp = 1'b1;
    man_inst = 32'h0000_0013;
    @(negedge clk_in);
    man_resp = 1'b0;
    check("f6_head", out_pc, 32'h100);
    @(negedge clk_in);
    check("f6_req_addr", icache_req_addr, 32'h104);
    man_resp = 1'b1;
    out_ready = 1'b1;
    flush_in = 1'b1;
    flush_pc = 32'h200;
    @(negedge clk_in);
    man_resp = 1'b0;
    out_ready = 1'b0;
    flush_in = 1'b0;
    check("f6_count", 32'(dbg_count), 32'd0);
    check("f6_out_valid", 32'(out_valid), 32'd0);
    check("f6_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk_in);
    check("f6_new_req", 32'(icache_req_valid), 32'd1);
    check("f6_new_addr", icache_req_addr, 32'h200);

    // reset mid-request, late response ignored
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mr_req_valid", 32'(icache_req_valid), 32'd0);
    man_resp = 1'b1;
    man_inst = 32'h0000_0013;
    @(negedge clk_in);
    man_resp = 1'b0;
    check("mr_late_ignored", 32'(dbg_count), 32'd0);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_req_addr", icache_req_addr, 32'h0);

    // prediction table
    auto_mode = 1'b1;
    lat = 0;
    foreach (vecs[i]) imem[vecs[i].pc] = vecs[i].inst;
    for (int i = 0; i < 7; i++) begin
      do_flush(vecs[i].pc);
      wait_out("tbl_out_valid");
      check("tbl_out_pc", out_pc, vecs[i].pc);
      check("tbl_out_inst", out_inst, vecs[i].inst);
      check("tbl_out_pred", out_pred_pc, vecs[i].exp_pred);
      wait_req("tbl_next_req");
      check("tbl_next_addr", icache_req_addr, vecs[i].exp_pred);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
